// File: rtl/mp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mp_pkg
// Purpose  : Shared widths and loader state encoding for the multi-precision
//            adder datapath and its wrappers.
// Revision : 1.0 - initial release
// ============================================================================
package mp_pkg;

  localparam int c_OPERAND_WIDTH = 512;
  localparam int c_WORD_WIDTH    = 32;

  typedef enum logic [1:0] {
    S_LOAD_A    = 2'd0,
    S_LOAD_B    = 2'd1,
    S_START     = 2'd2,
    S_WAIT_DONE = 2'd3
  } mpLoadState_e;

endpackage : mp_pkg
`default_nettype wire

// File: rtl/mp_word_shifter.sv
`default_nettype none
// ============================================================================
// Module   : mp_word_shifter
// Purpose  : Shift-in register; each load pushes a word into the MSBs and
//            shifts the contents right by one word.
// Revision : 1.0 - initial release
// ============================================================================
module mp_word_shifter
  import mp_pkg::*;
#(
  parameter int WIDTH      = c_OPERAND_WIDTH,
  parameter int WORD_WIDTH = c_WORD_WIDTH
) (
  input  logic                  iClk,
  input  logic                  iRstn,
  input  logic                  iLoad,
  input  logic [WORD_WIDTH-1:0] iWord,
  output logic [WIDTH-1:0]      oData
);

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_next;

  generate
    if (WIDTH > WORD_WIDTH) begin : g_multi
      assign w_next = {iWord, r_data[WIDTH-1:WORD_WIDTH]};
    end else begin : g_single
      assign w_next = iWord;
    end
  endgenerate

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      r_data <= '0;
    end else if (iLoad) begin
      r_data <= w_next;
    end
  end

  assign oData = r_data;

endmodule : mp_word_shifter
`default_nettype wire

// File: rtl/mp_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : mp_operand_loader
// Purpose  : Assembles operands A and B from a word stream, then starts the
//            multi-precision adder and waits for its completion.
// Revision : 1.0 - initial release
// ============================================================================
module mp_operand_loader
  import mp_pkg::*;
#(
  parameter int OPERAND_WIDTH = c_OPERAND_WIDTH,
  parameter int WORD_WIDTH    = c_WORD_WIDTH,
  parameter int N_WORDS       = OPERAND_WIDTH / WORD_WIDTH
) (
  input  logic                     iClk,
  input  logic                     iRstn,
  input  logic [WORD_WIDTH-1:0]    iWord,
  input  logic                     iWordValid,
  output logic                     oWordReady,
  input  logic                     iOpSub,
  output logic [OPERAND_WIDTH-1:0] oOpA,
  output logic [OPERAND_WIDTH-1:0] oOpB,
  output logic                     oAddSub,
  output logic                     oStart,
  input  logic                     iDone,
  output logic                     oBusy
);

  localparam int                 c_CNT_W     = $clog2(N_WORDS) + 1;
  localparam logic [c_CNT_W-1:0] c_LAST_WORD = c_CNT_W'(N_WORDS - 1);

  mpLoadState_e       r_state;
  logic [c_CNT_W-1:0] r_wordCnt;
  logic               r_addSub;
  logic               r_start;
  logic               r_busy;
  logic               r_wordReady;

  logic w_accept;
  logic w_lastWord;
  logic w_loadA;
  logic w_loadB;

  assign w_accept   = iWordValid & r_wordReady;
  assign w_lastWord = (r_wordCnt == c_LAST_WORD);
  assign w_loadA    = w_accept && (r_state == S_LOAD_A);
  assign w_loadB    = w_accept && (r_state == S_LOAD_B);

  mp_word_shifter #(
    .WIDTH      (OPERAND_WIDTH),
    .WORD_WIDTH (WORD_WIDTH)
  ) u_shiftA (
    .iClk  (iClk),
    .iRstn (iRstn),
    .iLoad (w_loadA),
    .iWord (iWord),
    .oData (oOpA)
  );

  mp_word_shifter #(
    .WIDTH      (OPERAND_WIDTH),
    .WORD_WIDTH (WORD_WIDTH)
  ) u_shiftB (
    .iClk  (iClk),
    .iRstn (iRstn),
    .iLoad (w_loadB),
    .iWord (iWord),
    .oData (oOpB)
  );

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      r_state     <= S_LOAD_A;
      r_wordCnt   <= '0;
      r_addSub    <= 1'b0;
      r_start     <= 1'b0;
      r_busy      <= 1'b0;
      r_wordReady <= 1'b1;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_LOAD_A: begin
          if (w_accept) begin
            // The operation select travels with the first A word only.
            if (r_wordCnt == '0) begin
              r_addSub <= iOpSub;
            end
            if (w_lastWord) begin
              r_state   <= S_LOAD_B;
              r_wordCnt <= '0;
            end else begin
              r_wordCnt <= r_wordCnt + 1'b1;
            end
          end
        end
        S_LOAD_B: begin
          if (w_accept) begin
            if (w_lastWord) begin
              r_state     <= S_START;
              r_wordCnt   <= '0;
              r_start     <= 1'b1;
              r_busy      <= 1'b1;
              r_wordReady <= 1'b0;
            end else begin
              r_wordCnt <= r_wordCnt + 1'b1;
            end
          end
        end
        S_START: begin
          r_state   <= S_WAIT_DONE;
          r_wordCnt <= '0;
        end
        S_WAIT_DONE: begin
          if (iDone) begin
            r_state     <= S_LOAD_A;
            r_wordCnt   <= '0;
            r_busy      <= 1'b0;
            r_wordReady <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_LOAD_A;
          r_wordCnt   <= '0;
          r_busy      <= 1'b0;
          r_wordReady <= 1'b1;
        end
      endcase
    end
  end

  assign oWordReady = r_wordReady;
  assign oAddSub    = r_addSub;
  assign oStart     = r_start;
  assign oBusy      = r_busy;

endmodule : mp_operand_loader
`default_nettype wire

// File: tb/tb_mp_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mp_operand_loader
// Purpose  : Directed self-checking bench for the operand loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mp_operand_loader;

  localparam int OW = 512;
  localparam int WW = 32;
  localparam int NW = 16;

  logic          iClk = 1'b0;
  logic          iRstn = 1'b0;
  logic [WW-1:0] iWord = '0;
  logic          iWordValid = 1'b0;
  logic          iOpSub = 1'b0;
  logic          iDone = 1'b0;
  logic          oWordReady;
  logic [OW-1:0] oOpA;
  logic [OW-1:0] oOpB;
  logic          oAddSub;
  logic          oStart;
  logic          oBusy;

  int nCompared   = 0;
  int nMismatched = 0;
  int startCnt    = 0;
  int startBase   = 0;

  logic [WW-1:0] wa [NW];
  logic [WW-1:0] wb [NW];
  logic [OW-1:0] expA;
  logic [OW-1:0] expB;

  mp_operand_loader #(
    .OPERAND_WIDTH (OW),
    .WORD_WIDTH    (WW),
    .N_WORDS       (NW)
  ) dut (
    .iClk       (iClk),
    .iRstn      (iRstn),
    .iWord      (iWord),
    .iWordValid (iWordValid),
    .oWordReady (oWordReady),
    .iOpSub     (iOpSub),
    .oOpA       (oOpA),
    .oOpB       (oOpB),
    .oAddSub    (oAddSub),
    .oStart     (oStart),
    .iDone      (iDone),
    .oBusy      (oBusy)
  );

  always #5 iClk = ~iClk;

  always @(negedge iClk) begin
    if (oStart) startCnt++;
  end

  task automatic checkVal(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] packWords(input logic [WW-1:0] w [NW]);
    logic [OW-1:0] r;
    r = '0;
    for (int i = 0; i < NW; i++) r[i*WW +: WW] = w[i];
    return r;
  endfunction

  // Presents one word and returns 1 time unit after the edge that accepted it.
  task automatic sendWord(input logic [WW-1:0] w, input logic sub, input int gap);
    int waited;
    repeat (gap) @(negedge iClk);
    @(negedge iClk);
    iWord      = w;
    iOpSub     = sub;
    iWordValid = 1'b1;
    waited     = 0;
    while (!oWordReady && waited < 50) begin
      @(negedge iClk);
      waited++;
    end
    if (waited >= 50) checkVal("acceptTimeout", 1'b0, 1'b1);
    @(posedge iClk);
    #1;
    iWordValid = 1'b0;
  endtask

  task automatic finishOp();
    @(negedge iClk);
    iDone = 1'b1;
    @(posedge iClk);
    #1;
    iDone = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge iClk);
    checkVal("rstOpA", oOpA, '0);
    checkVal("rstOpB", oOpB, '0);
    checkVal("rstAddSub", oAddSub, 1'b0);
    checkVal("rstStart", oStart, 1'b0);
    checkVal("rstBusy", oBusy, 1'b0);
    iRstn = 1'b1;
    @(negedge iClk);
    checkVal("rstReady", oWordReady, 1'b1);

    // A = 1, B = all ones, add
    for (int i = 0; i < NW; i++) begin
      wa[i] = (i == 0) ? 32'h1 : 32'h0;
      wb[i] = 32'hFFFF_FFFF;
    end
    startBase = startCnt;
    for (int i = 0; i < NW; i++) sendWord(wa[i], 1'b0, 0);
    for (int i = 0; i < NW; i++) sendWord(wb[i], 1'b0, 0);
    checkVal("t1Start", oStart, 1'b1);
    checkVal("t1Busy", oBusy, 1'b1);
    checkVal("t1ReadyLow", oWordReady, 1'b0);
    checkVal("t1OpA", oOpA, {{(OW-1){1'b0}}, 1'b1});
    checkVal("t1OpB", oOpB, {OW{1'b1}});
    checkVal("t1AddSub", oAddSub, 1'b0);
    @(posedge iClk);
    #1;
    checkVal("t1StartOff", oStart, 1'b0);
    checkVal("t1BusyWait", oBusy, 1'b1);
    checkVal("t1StartCnt", startCnt - startBase, 1);

    // Valid held high while waiting for done: nothing is accepted
    @(negedge iClk);
    iWord      = 32'hDEAD_BEEF;
    iWordValid = 1'b1;
    repeat (3) @(negedge iClk);
    checkVal("waitReady", oWordReady, 1'b0);
    checkVal("waitOpA", oOpA, {{(OW-1){1'b0}}, 1'b1});
    checkVal("waitOpB", oOpB, {OW{1'b1}});
    iDone = 1'b1;
    @(posedge iClk);
    #1;
    iDone      = 1'b0;
    iWordValid = 1'b0;
    checkVal("doneReady", oWordReady, 1'b1);
    checkVal("doneBusy", oBusy, 1'b0);
    checkVal("doneOpAHeld", oOpA, {{(OW-1){1'b0}}, 1'b1});

    // A = 0..F, subtract latched on first word, iOpSub toggled afterwards
    for (int i = 0; i < NW; i++) begin
      wa[i] = WW'(i);
      wb[i] = 32'hA500_0000 | WW'(i * 3);
    end
    expA = packWords(wa);
    expB = packWords(wb);
    startBase = startCnt;
    for (int i = 0; i < NW; i++) begin
      sendWord(wa[i], (i % 2 == 0), 0);
      if (i == 0) checkVal("t2SubLatched", oAddSub, 1'b1);
    end
    checkVal("t2OpALow", oOpA[31:0], 32'h0);
    checkVal("t2OpAHigh", oOpA[511:480], 32'hF);
    checkVal("t2SubHeld", oAddSub, 1'b1);
    for (int i = 0; i < NW; i++) begin
      if (i == 8) begin
        @(negedge iClk);
        iDone = 1'b1;
        @(negedge iClk);
        iDone = 1'b0;
        checkVal("spuriousReady", oWordReady, 1'b1);
        checkVal("spuriousBusy", oBusy, 1'b0);
        checkVal("spuriousStart", oStart, 1'b0);
      end
      sendWord(wb[i], (i % 2 == 1), int'($urandom_range(0, 3)));
    end
    checkVal("t2Start", oStart, 1'b1);
    checkVal("t2OpA", oOpA, expA);
    checkVal("t2OpB", oOpB, expB);
    checkVal("t2AddSub", oAddSub, 1'b1);
    repeat (4) @(negedge iClk);
    checkVal("t2StartCnt", startCnt - startBase, 1);
    checkVal("t2SubInWait", oAddSub, 1'b1);
    finishOp();

    // Next first word with add replaces the latched select; then reset after 20 accepts
    for (int i = 0; i < NW; i++) wa[i] = 32'h1111_0000 + WW'(i);
    startBase = startCnt;
    sendWord(wa[0], 1'b0, 0);
    checkVal("t3SubReleased", oAddSub, 1'b0);
    checkVal("t3FirstShift", oOpA, {wa[0], expA[OW-1:WW]});
    for (int i = 1; i < NW; i++) sendWord(wa[i], 1'b1, 0);
    for (int i = 0; i < 4; i++) sendWord(32'h2222_0000 + WW'(i), 1'b0, 0);
    @(negedge iClk);
    #2;
    iRstn = 1'b0;
    #1;
    checkVal("midRstOpA", oOpA, '0);
    checkVal("midRstOpB", oOpB, '0);
    checkVal("midRstBusy", oBusy, 1'b0);
    checkVal("midRstStart", oStart, 1'b0);
    repeat (2) @(negedge iClk);
    iRstn = 1'b1;
    repeat (40) @(negedge iClk);
    checkVal("midRstNoStart", startCnt - startBase, 0);
    checkVal("postRstReady", oWordReady, 1'b1);

    // Full load after reset
    for (int i = 0; i < NW; i++) begin
      wa[i] = WW'(i) * 32'h0101_0101;
      wb[i] = ~(WW'(i) * 32'h0101_0101);
    end
    expA = packWords(wa);
    expB = packWords(wb);
    for (int i = 0; i < NW; i++) sendWord(wa[i], (i == 0), 0);
    for (int i = 0; i < NW; i++) sendWord(wb[i], 1'b0, int'($urandom_range(0, 2)));
    checkVal("t4Start", oStart, 1'b1);
    checkVal("t4OpA", oOpA, expA);
    checkVal("t4OpB", oOpB, expB);
    checkVal("t4AddSub", oAddSub, 1'b1);
    repeat (3) @(negedge iClk);
    checkVal("t4StartCnt", startCnt - startBase, 1);
    finishOp();
    checkVal("t4Ready", oWordReady, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule : tb_mp_operand_loader
`default_nettype wire

// File: doc/mp_operand_loader.md
MP_OPERAND_LOADER -- requirements
Module: mp_operand_loader

Interface
REQ-001 The block SHALL have parameter OPERAND_WIDTH, default 512, giving the width of each operand delivered to the multi-precision adder.
REQ-002 The block SHALL have parameter WORD_WIDTH, default 32, giving the width of the input word stream; OPERAND_WIDTH SHALL be an integer multiple of WORD_WIDTH.
REQ-003 The block SHALL have parameter N_WORDS, default OPERAND_WIDTH/WORD_WIDTH, giving the number of words per operand.
REQ-004 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-005 Port iClk, input, 1 bit: the single clock, rising-edge active.
REQ-006 Port iRstn, input, 1 bit: asynchronous active-low reset.
REQ-007 Port iWord, input, WORD_WIDTH bits: operand word stream, least-significant word first.
REQ-008 Port iWordValid, input, 1 bit: iWord holds a valid word.
REQ-009 Port oWordReady, output, 1 bit: the block accepts iWord this cycle.
REQ-010 Port iOpSub, input, 1 bit: operation select, 0 = add, 1 = subtract; sampled with the first word of A.
REQ-011 Port oOpA, output, OPERAND_WIDTH bits: assembled operand A, drives the adder iOpA.
REQ-012 Port oOpB, output, OPERAND_WIDTH bits: assembled operand B, drives the adder iOpB.
REQ-013 Port oAddSub, output, 1 bit: latched operation select, drives the adder iAddSub.
REQ-014 Port oStart, output, 1 bit: single-cycle start pulse, drives the adder iStart.
REQ-015 Port iDone, input, 1 bit: adder completion pulse, driven by the adder oDone.
REQ-016 Port oBusy, output, 1 bit: high from oStart until iDone is received.

Function
REQ-017 A word SHALL be accepted on a rising edge where iWordValid and oWordReady are both 1; no other edge SHALL change the assembly registers.
REQ-018 The FSM SHALL have exactly these states: S_LOAD_A, S_LOAD_B, S_START, S_WAIT_DONE.
REQ-019 In S_LOAD_A and S_LOAD_B, oWordReady SHALL be 1; in S_START and S_WAIT_DONE, oWordReady SHALL be 0.
REQ-020 Each accepted word SHALL enter the MSB WORD_WIDTH bits of the active operand register while the register shifts right by WORD_WIDTH, so that after N_WORDS accepts the first word occupies bits [WORD_WIDTH-1:0].
REQ-021 A word counter of width $clog2(N_WORDS)+1 SHALL count accepts; it SHALL clear on every state change.
REQ-022 S_LOAD_A SHALL move to S_LOAD_B on the accept of the N_WORDS-th word; S_LOAD_B SHALL move to S_START on the accept of the N_WORDS-th word.
REQ-023 iOpSub SHALL be latched into oAddSub on the accept of the first word in S_LOAD_A, and at no other time.
REQ-024 oStart SHALL be 1 for exactly one cycle, the cycle spent in S_START, which begins one cycle after the last B word is accepted; S_START SHALL always move to S_WAIT_DONE.
REQ-025 S_WAIT_DONE SHALL move to S_LOAD_A on the first cycle in which iDone is 1.
REQ-026 oOpA, oOpB and oAddSub SHALL remain stable from S_START until the first word of the next operation is accepted, because the adder samples the operands after start and uses iAddSub combinationally on its result.
REQ-027 iDone SHALL be ignored in every state other than S_WAIT_DONE.
REQ-028 iWordValid with no handshake SHALL leave the block unchanged; gaps between words of any length are legal.
REQ-029 oBusy SHALL be 1 in S_START and S_WAIT_DONE, and 0 otherwise.

Reset
REQ-030 On iRstn low, asynchronously: the state SHALL be S_LOAD_A, the counter 0, oOpA/oOpB all-zero, oAddSub 0, oStart 0, oBusy 0; oWordReady SHALL be 1 once reset is released.
REQ-031 Reset asserted mid-operation SHALL discard any partial operands without emitting oStart.

Structure
REQ-032 State encodings and default widths (512, 32) SHALL live in a shared package mp_pkg, also usable by the adder wrappers.
REQ-033 The operand assembly SHALL use one sub-module, mp_word_shifter (parameterised shift-in register with load enable), instantiated twice, once for A and once for B.

Verification
REQ-034 Reset, then stream 16 words A = 0x00000001,0,...,0 and 16 words B = 0xFFFFFFFF x16 with iOpSub = 0 -> oOpA = 1, oOpB = 2^512-1, oStart pulses once exactly one cycle after the 32nd accept.
REQ-035 Stream A words 0x0..0xF (LS first) -> oOpA[31:0] = 0, oOpA[511:480] = 0xF.
REQ-036 iOpSub = 1 on the first A word, then toggled during the remaining words -> oAddSub = 1 and held until the next first-word accept.
REQ-037 Random iWordValid gaps plus an iDone pulse injected during S_LOAD_B -> identical operands, no state change from the spurious iDone, oStart pulses exactly once.
REQ-038 In S_WAIT_DONE, hold iWordValid = 1 -> oWordReady = 0 and no accept; after iDone = 1 -> next cycle in S_LOAD_A with oWordReady = 1.
REQ-039 Assert iRstn low after 20 accepted words -> all outputs reset immediately, no oStart, and a following full 32-word load completes normally.
